// File: rtl/mxfp_block_packer.sv
// Serialises one MX block (k element codes + 8-bit shared scale) onto a word
// stream: a scale word, then ceil(k/epw) packed element words.
module mxfp_block_packer #(
    parameter int unsigned exp_width = 5,
    parameter int unsigned man_width = 2,
    parameter int unsigned k         = 32,
    parameter int unsigned out_width = 64,
    localparam int unsigned bit_width = 1 + exp_width + man_width
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [bit_width-1:0] i_mx_vec [k],
    input  logic [7:0]           i_mx_exp,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [out_width-1:0] o_data,
    output logic                 o_first,
    output logic                 o_last
);

    localparam int unsigned epw          = out_width / bit_width;
    localparam int unsigned n_elem_words = (k + epw - 1) / epw;
    localparam int unsigned ww           = (n_elem_words > 1) ? $clog2(n_elem_words) : 1;
    localparam int unsigned iw           = (k > 1) ? $clog2(k) : 1;
    localparam logic [ww-1:0] last_w     = ww'(n_elem_words - 1);

    typedef enum logic [1:0] {IDLE, SCALE, ELEM} state_t;

    state_t               state_q, state_d;
    logic [ww-1:0]        wcnt_q, wcnt_d;
    logic [7:0]           scale_q, scale_d;
    logic [bit_width-1:0] vec_q [k];
    logic [bit_width-1:0] vec_d [k];
    logic                 valid_q, valid_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic [out_width-1:0] data_q, data_d;
    logic                 in_xfer, out_xfer;
    int unsigned          elem_idx;

    // Accepting during the last element word's transfer gives zero-bubble blocks.
    assign o_ready = (state_q == IDLE) ||
                     ((state_q == ELEM) && (wcnt_q == last_w) && i_ready);
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_first = first_q;
    assign o_last  = last_q;

    always_comb begin
        in_xfer  = i_valid && o_ready;
        out_xfer = valid_q && i_ready;
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        scale_d  = scale_q;
        vec_d    = vec_q;
        elem_idx = 0;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    vec_d   = i_mx_vec;
                    scale_d = i_mx_exp;
                    state_d = SCALE;
                end
            end
            SCALE: begin
                if (out_xfer) begin
                    wcnt_d  = '0;
                    state_d = ELEM;
                end
            end
            ELEM: begin
                if (out_xfer) begin
                    if (wcnt_q == last_w) begin
                        if (in_xfer) begin
                            vec_d   = i_mx_vec;
                            scale_d = i_mx_exp;
                            state_d = SCALE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are built from the next state so they are registered yet current.
        valid_d = (state_d != IDLE);
        first_d = (state_d == SCALE);
        last_d  = (state_d == ELEM) && (wcnt_d == last_w);
        data_d  = '0;
        if (state_d == SCALE) begin
            data_d[7:0] = scale_d;
        end else if (state_d == ELEM) begin
            for (int unsigned e = 0; e < epw; e++) begin
                elem_idx = 32'(wcnt_d) * epw + e;
                if (elem_idx < k) begin
                    data_d[e*bit_width +: bit_width] = vec_d[elem_idx[iw-1:0]];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            scale_q <= '0;
            vec_q   <= '{default: '0};
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            scale_q <= scale_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

endmodule
